// File: rtl/alu_mon_pkg.sv
// Shared field layout and FSM encoding for the ALU result monitor.
// Records are packed as {opcode, in_a, in_b, alu_out, a_in_zero}, MSB first.
package alu_mon_pkg;

    localparam int OPC_W   = 4;
    localparam int OPD_W   = 4;
    localparam int RES_W   = 5;
    localparam int TUP_W   = OPC_W + 2 * OPD_W;
    localparam int REC_W   = 18;

    localparam int ZF_LSB  = 0;
    localparam int RES_LSB = ZF_LSB + 1;
    localparam int B_LSB   = RES_LSB + RES_W;
    localparam int A_LSB   = B_LSB + OPD_W;
    localparam int OPC_LSB = A_LSB + OPD_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } mon_state_e;

    function automatic logic [REC_W-1:0] pack_record(
        input logic [OPC_W-1:0] opc,
        input logic [OPD_W-1:0] a,
        input logic [OPD_W-1:0] b,
        input logic [RES_W-1:0] res,
        input logic             zf
    );
        return {opc, a, b, res, zf};
    endfunction

endpackage

// File: rtl/alu_mon_fifo.sv
// First-word fall-through FIFO with a registered head word.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module alu_mon_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic             valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(32'd1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      wr_ptr_nxt_s;
    logic [AW:0]      rd_ptr_nxt_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             full_s;
    logic             empty_s;
    logic             valid_r;
    logic [WIDTH-1:0] rd_data_r;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);

    // Accept/advance decisions; a full FIFO still accepts when it pops in the same cycle.
    always_comb begin
        pop_ok_s     = pop && !empty_s;
        push_ok_s    = push && (!full_s || pop_ok_s);
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_ok_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Pointers and registered head; the head bypasses from wr_data when the new word is the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= {(AW + 1){1'b0}};
            rd_ptr_r  <= {(AW + 1){1'b0}};
            valid_r   <= 1'b0;
            rd_data_r <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            valid_r  <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
            if (wr_ptr_nxt_s != rd_ptr_nxt_s) begin
                if (rd_ptr_nxt_s == wr_ptr_r) begin
                    rd_data_r <= wr_data;
                end else begin
                    rd_data_r <= mem_r[rd_ptr_nxt_s[AW-1:0]];
                end
            end
        end
    end

    assign full    = full_s;
    assign empty   = empty_s;
    assign valid   = valid_r;
    assign rd_data = rd_data_r;

endmodule

// File: rtl/alu_result_monitor.sv
// Captures one {opcode, operands, result, zero flag} record per stable ALU tuple
// and queues it for a valid/ready consumer, counting captures lost to a full queue.
module alu_result_monitor
    import alu_mon_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [3:0]       opcode,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [4:0]       alu_out,
    input  logic             a_in_zero,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [17:0]      rd_data,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES - 32'sd1);
    localparam logic [SC_W-1:0]  SC_ONE      = SC_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);

    mon_state_e       state_r;
    logic [TUP_W-1:0] prev_t_r;
    logic             primed_r;
    logic [SC_W-1:0]  cnt_r;
    logic             busy_r;
    logic             overflow_r;
    logic [CNT_W-1:0] drop_cnt_r;

    logic [TUP_W-1:0] tuple_s;
    logic             change_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic             full_s;
    logic             empty_s;
    logic [REC_W-1:0] record_s;

    assign tuple_s  = {opcode, in_a, in_b};
    assign change_s = !primed_r || (tuple_s != prev_t_r);
    assign record_s = pack_record(opcode, in_a, in_b, alu_out, a_in_zero);

    // Capture strobe: the tuple survived the full settle window unchanged.
    always_comb begin
        push_s = 1'b0;
        if (!rst && sample_en && (state_r == ST_SETTLE) && !change_s && (cnt_r == SETTLE_LAST)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        pop_s  = !empty_s && rd_ready;
        drop_s = push_s && full_s && !pop_s;
    end

    // Settle FSM; dropping sample_en abandons any settle but keeps the primed flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            prev_t_r <= {TUP_W{1'b0}};
            primed_r <= 1'b0;
            cnt_r    <= {SC_W{1'b0}};
            busy_r   <= 1'b0;
        end else if (!sample_en) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (change_s) begin
                        prev_t_r <= tuple_s;
                        primed_r <= 1'b1;
                        cnt_r    <= {SC_W{1'b0}};
                        state_r  <= ST_SETTLE;
                        busy_r   <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (change_s) begin
                        prev_t_r <= tuple_s;
                        cnt_r    <= {SC_W{1'b0}};
                    end else if (cnt_r == SETTLE_LAST) begin
                        state_r <= ST_HOLD;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + SC_ONE;
                    end
                end
                ST_HOLD: begin
                    if (change_s) begin
                        prev_t_r <= tuple_s;
                        cnt_r    <= {SC_W{1'b0}};
                        state_r  <= ST_SETTLE;
                        busy_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {CNT_W{1'b0}};
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != CNT_MAX) begin
                drop_cnt_r <= drop_cnt_r + CNT_ONE;
            end
        end
    end

    alu_mon_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (record_s),
        .full    (full_s),
        .empty   (empty_s),
        .valid   (rd_valid),
        .rd_data (rd_data)
    );

    assign overflow = overflow_r;
    assign drop_cnt = drop_cnt_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_alu_result_monitor.sv
// Directed scenarios plus a randomized phase, all checked every cycle against
// a queue-based model of capture, settle-run and drop behaviour.
module tb_alu_result_monitor;

    localparam int DEPTH = 8;
    localparam int SC    = 2;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             sample_en;
    logic [3:0]       opcode;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic [4:0]       alu_out;
    logic             a_in_zero;
    logic             rd_valid;
    logic             rd_ready;
    logic [17:0]      rd_data;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;
    logic             busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [17:0] mq[$];
    logic [11:0] m_last;
    logic        m_primed;
    int          m_run;
    logic        m_over;
    int          m_drop;
    logic [17:0] m_data;

    alu_result_monitor #(
        .DEPTH         (DEPTH),
        .SETTLE_CYCLES (SC),
        .CNT_W         (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .opcode    (opcode),
        .in_a      (in_a),
        .in_b      (in_b),
        .alu_out   (alu_out),
        .a_in_zero (a_in_zero),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge as seen by the model: a tuple run that reaches SC edges captures once.
    task automatic model_edge();
        logic pop;
        logic cap;
        logic was_full;
        if (rst) begin
            mq.delete();
            m_primed = 1'b0;
            m_run    = -1;
            m_over   = 1'b0;
            m_drop   = 0;
            m_data   = 18'd0;
        end else begin
            pop      = (mq.size() > 0) && rd_ready;
            was_full = (mq.size() == DEPTH);
            cap      = 1'b0;
            if (!sample_en) begin
                m_run = -1;
            end else if (!m_primed || ({opcode, in_a, in_b} != m_last)) begin
                m_last   = {opcode, in_a, in_b};
                m_primed = 1'b1;
                m_run    = 0;
            end else if (m_run >= 0) begin
                m_run++;
                if (m_run == SC) cap = 1'b1;
            end
            if (pop) void'(mq.pop_front());
            if (cap) begin
                if (was_full && !pop) begin
                    m_over = 1'b1;
                    if (m_drop < (1 << CNT_W) - 1) m_drop++;
                end else begin
                    mq.push_back({opcode, in_a, in_b, alu_out, a_in_zero});
                end
            end
            if (mq.size() > 0) m_data = mq[0];
        end
    endtask

    task automatic check_all();
        chk("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
        chk("rd_data", 32'(rd_data), 32'(m_data));
        chk("overflow", 32'(overflow), 32'(m_over));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("busy", 32'(busy), 32'((m_run >= 0) && (m_run < SC)));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_tuple(input int op, input int a, input int b);
        opcode = 4'(op);
        in_a   = 4'(a);
        in_b   = 4'(b);
    endtask

    initial begin
        logic [17:0] exp_rec;
        int          exp_ops[8] = '{2, 3, 4, 5, 6, 7, 8, 10};
        int          n;

        rst = 1'b1; sample_en = 1'b0; rd_ready = 1'b0;
        set_tuple(0, 0, 0); alu_out = 5'd0; a_in_zero = 1'b0;
        step(); step();
        chk("reset_valid", 32'(rd_valid), 32'd0);
        chk("reset_data", 32'(rd_data), 32'd0);
        rst = 1'b0;

        // 1: basic capture with two-edge latency
        sample_en = 1'b1;
        set_tuple(1, 7, 15); alu_out = 5'b10110; a_in_zero = 1'b0;
        step();
        chk("t1_busy_e0", 32'(busy), 32'd1);
        step();
        chk("t1_valid_e1", 32'(rd_valid), 32'd0);
        step();
        exp_rec = 18'b0001_0111_1111_10110_0;
        chk("t1_valid_e2", 32'(rd_valid), 32'd1);
        chk("t1_record", 32'(rd_data), 32'(exp_rec));
        for (int i = 0; i < 4; i++) step();
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        chk("t1_single", 32'(rd_valid), 32'd0);

        // 2: settle restart on in_b change
        set_tuple(3, 12, 15); alu_out = 5'd9;
        step();
        set_tuple(3, 12, 0);
        step(); step();
        chk("t2_busy3", 32'(busy), 32'd1);
        step();
        chk("t2_busy_done", 32'(busy), 32'd0);
        chk("t2_b_zero", 32'(rd_data[9:6]), 32'd0);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        step(); step();
        chk("t2_one_record", 32'(rd_valid), 32'd0);

        // 3: overflow with nine captures into eight slots
        for (int op = 1; op <= 9; op++) begin
            set_tuple(op, op, 15 - op); alu_out = 5'(op * 3);
            step(); step(); step();
        end
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("t3_head_op", 32'(rd_data[17:14]), 32'd1);

        // 4: full FIFO with pop on the capture edge
        set_tuple(10, 1, 2);
        step(); step();
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        chk("t4_drop_same", 32'(drop_cnt), 32'd1);
        rd_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (rd_valid) begin
                if (n < 8) chk("t4_drain_op", 32'(rd_data[17:14]), 32'(exp_ops[n]));
                n++;
            end
            step();
        end
        rd_ready = 1'b0;
        chk("t4_occupancy", 32'(n), 32'd8);

        // 5: backpressure keeps rd_data stable
        set_tuple(7, 7, 3); alu_out = 5'd21; a_in_zero = 1'b1;
        step(); step(); step();
        exp_rec = {4'd7, 4'd7, 4'd3, 5'd21, 1'b1};
        alu_out = 5'd2; a_in_zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_stable", 32'(rd_data), 32'(exp_rec));
        end
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        chk("t5_popped", 32'(rd_valid), 32'd0);

        // 6: reset mid-settle with records queued
        for (int op = 4; op <= 6; op++) begin
            set_tuple(op, 1, 1); step(); step(); step();
        end
        set_tuple(12, 5, 5);
        step();
        chk("t6_settling", 32'(busy), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_valid", 32'(rd_valid), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        step(); step(); step();
        chk("t6_recapture", 32'(rd_valid), 32'd1);
        chk("t6_op", 32'(rd_data[17:14]), 32'd12);
        rd_ready = 1'b1; step();

        // Randomized traffic on a small tuple space so repeats occur
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) set_tuple($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            alu_out   = 5'($urandom);
            a_in_zero = 1'($urandom);
            sample_en = ($urandom_range(0, 9) != 0);
            rd_ready  = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
